// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command, ALU and response signal bundle for alu_sequencer
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_result;
  logic [2:0] rsp_opcode;
  logic       rsp_mismatch;
  logic [7:0] op_count;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_result,
           rsp_opcode, rsp_mismatch, op_count
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_result,
           rsp_opcode, rsp_mismatch, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - drives one command onto an external ALU, waits SETTLE_CYCLES, returns the result
// Optional golden-model result check enabled by macro ALU_SEQ_CHECK_EN.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic [2:0] alu_opcode_q, alu_opcode_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [4:0] rsp_result_q, rsp_result_d;
  logic [2:0] rsp_opcode_q, rsp_opcode_d;
  logic [7:0] op_count_q, op_count_d;
  logic       capture;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_ready_d  = cmd_ready_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_opcode_d = rsp_opcode_q;
    op_count_d   = op_count_q;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          alu_opcode_d = bus.cmd_opcode;
          alu_a_d      = bus.cmd_a;
          alu_b_d      = bus.cmd_b;
          cnt_d        = SETTLE_INIT;
          cmd_ready_d  = 1'b0;
          state_d      = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // A zero count is treated like one so a bad parameter cannot hang here.
        if (cnt_q <= 4'd1) begin
          capture      = 1'b1;
          cnt_d        = 4'd0;
          rsp_result_d = bus.alu_result;
          rsp_opcode_d = alu_opcode_q;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      cmd_ready_q  <= 1'b0;
      alu_opcode_q <= 3'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 5'd0;
      rsp_opcode_q <= 3'd0;
      op_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_opcode_q <= rsp_opcode_d;
      op_count_q   <= op_count_d;
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [4:0] expected;
  logic       mismatch_q, mismatch_d;

  always_comb begin
    expected = 5'd0;
    case (alu_opcode_q)
      3'b000: expected = {1'b0, alu_a_q} + {1'b0, alu_b_q};
      3'b001: expected = {1'b0, alu_a_q} - {1'b0, alu_b_q};
      3'b010: expected = {1'b0, alu_a_q | alu_b_q};
      3'b011: expected = {1'b0, alu_a_q & alu_b_q};
      3'b100: expected = {1'b0, alu_a_q} + 5'd1;
      3'b101: expected = {1'b0, alu_a_q} - 5'd1;
      3'b110: expected = {1'b0, alu_b_q} + 5'd1;
      default: expected = {1'b0, alu_b_q} - 5'd1;
    endcase
    mismatch_d = capture ? (bus.alu_result != expected) : mismatch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign bus.rsp_mismatch = mismatch_q;
`else
  assign bus.rsp_mismatch = 1'b0;
`endif

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench for alu_sequencer with SETTLE_CYCLES 1 and 4
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst1;
  logic rst4;
  logic bad1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_cnt1 = 8'd0;

  always #5 clk = ~clk;

  alu_sequencer_if b1();
  alu_sequencer_if b4();

  alu_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(b1));
  alu_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(b4));

  function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a | b};
      3'd3: return {1'b0, a & b};
      3'd4: return {1'b0, a} + 5'd1;
      3'd5: return {1'b0, a} - 5'd1;
      3'd6: return {1'b0, b} + 5'd1;
      default: return {1'b0, b} - 5'd1;
    endcase
  endfunction

  assign b1.alu_result = bad1 ? 5'd0 : alu_f(b1.alu_opcode, b1.alu_a, b1.alu_b);
  assign b4.alu_result = alu_f(b4.alu_opcode, b4.alu_a, b4.alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_op1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] exp_res, input logic exp_mm, input int hold);
    int cyc;
    logic mm;
`ifdef ALU_SEQ_CHECK_EN
    mm = exp_mm;
`else
    mm = 1'b0;
`endif
    chk("pre_ready", b1.cmd_ready, 1);
    b1.cmd_opcode = op;
    b1.cmd_a      = a;
    b1.cmd_b      = b;
    b1.cmd_valid  = 1'b1;
    @(negedge clk);
    b1.cmd_valid  = 1'b0;
    b1.cmd_opcode = ~op;
    b1.cmd_a      = ~a;
    chk("alu_a_latched", b1.alu_a, a);
    chk("drive_not_ready", b1.cmd_ready, 0);
    cyc = 1;
    while (!b1.rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency1", cyc, 2);
    chk("rsp_result", b1.rsp_result, exp_res);
    chk("rsp_opcode", b1.rsp_opcode, op);
    chk("rsp_mismatch", b1.rsp_mismatch, mm);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", b1.rsp_valid, 1);
      chk("hold_result", b1.rsp_result, exp_res);
      chk("hold_not_ready", b1.cmd_ready, 0);
    end
    b1.rsp_ready = 1'b1;
    @(negedge clk);
    b1.rsp_ready = 1'b0;
    exp_cnt1 = exp_cnt1 + 8'd1;
    chk("post_valid", b1.rsp_valid, 0);
    chk("post_ready", b1.cmd_ready, 1);
    chk("op_count", b1.op_count, exp_cnt1);
    chk("alu_a_held", b1.alu_a, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst1 = 1'b1; rst4 = 1'b1; bad1 = 1'b0;
    b1.cmd_valid = 1'b0; b1.cmd_opcode = 3'd0; b1.cmd_a = 4'd0; b1.cmd_b = 4'd0; b1.rsp_ready = 1'b0;
    b4.cmd_valid = 1'b0; b4.cmd_opcode = 3'd0; b4.cmd_a = 4'd0; b4.cmd_b = 4'd0; b4.rsp_ready = 1'b0;

    // Reset held three cycles; a command offered meanwhile must not be taken.
    b1.cmd_valid = 1'b1; b1.cmd_a = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_cmd_ready", b1.cmd_ready, 0);
      chk("rst_rsp_valid", b1.rsp_valid, 0);
      chk("rst_rsp_result", b1.rsp_result, 0);
      chk("rst_rsp_opcode", b1.rsp_opcode, 0);
      chk("rst_rsp_mismatch", b1.rsp_mismatch, 0);
      chk("rst_alu", {b1.alu_opcode, b1.alu_a, b1.alu_b}, 0);
      chk("rst_op_count", b1.op_count, 0);
    end
    b1.cmd_valid = 1'b0; b1.cmd_a = 4'd0;
    rst1 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("first_ready", b1.cmd_ready, 1);
    chk("first_ready4", b4.cmd_ready, 1);
    chk("idle_alu_a", b1.alu_a, 0);

    run_op1(3'b000, 4'd9,  4'd8,  5'd17, 1'b0, 1);
    run_op1(3'b001, 4'd3,  4'd5,  5'd30, 1'b0, 1);
    run_op1(3'b101, 4'd0,  4'd7,  5'd31, 1'b0, 1);
    run_op1(3'b010, 4'd12, 4'd3,  5'd15, 1'b0, 5);
    run_op1(3'b011, 4'd12, 4'd10, 5'd8,  1'b0, 1);
    run_op1(3'b100, 4'd15, 4'd0,  5'd16, 1'b0, 2);
    run_op1(3'b110, 4'd0,  4'd15, 5'd16, 1'b0, 1);
    run_op1(3'b111, 4'd2,  4'd0,  5'd31, 1'b0, 1);
    bad1 = 1'b1;
    run_op1(3'b000, 4'd1,  4'd1,  5'd0,  1'b1, 1);
    bad1 = 1'b0;
    run_op1(3'b000, 4'd1,  4'd1,  5'd2,  1'b0, 1);

    // SETTLE_CYCLES=4: latency, then reset in the middle of DRIVE.
    b4.cmd_opcode = 3'b100; b4.cmd_a = 4'd6; b4.cmd_b = 4'd0; b4.cmd_valid = 1'b1;
    @(negedge clk);
    b4.cmd_valid = 1'b0;
    cyc = 1;
    while (!b4.rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency4", cyc, 5);
    chk("rsp_result4", b4.rsp_result, 7);
    b4.rsp_ready = 1'b1;
    @(negedge clk);
    b4.rsp_ready = 1'b0;
    chk("op_count4", b4.op_count, 1);

    b4.cmd_opcode = 3'b000; b4.cmd_a = 4'd3; b4.cmd_b = 4'd4; b4.cmd_valid = 1'b1;
    @(negedge clk);
    b4.cmd_valid = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    chk("rst4_valid", b4.rsp_valid, 0);
    chk("rst4_ready", b4.cmd_ready, 0);
    chk("rst4_alu_a", b4.alu_a, 0);
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b4.rsp_valid) cyc++;
    end
    chk("rst4_no_rsp", cyc, 0);
    chk("rst4_op_count", b4.op_count, 0);
    chk("rst4_ready_after", b4.cmd_ready, 1);

    // Complete ops on the SETTLE_CYCLES=1 instance until 256 in total.
    while (exp_cnt1 != 8'd255) begin
      run_op1(3'b000, exp_cnt1[3:0], 4'd0, {1'b0, exp_cnt1[3:0]}, 1'b0, 1);
    end
    chk("count_255", b1.op_count, 255);
    run_op1(3'b110, 4'd0, 4'd4, 5'd5, 1'b0, 1);
    chk("count_wrap", b1.op_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
